// File: rtl/eth_tx_arbiter.sv
// Frame-level round-robin arbiter in front of a single GMII transmit MAC.
// The granted lane is passed through combinationally; frames are followed by an inter-frame gap.
module eth_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IFG_CYCLES = 12,
    parameter int MAX_LEN    = 1518
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_sof,
    input  logic [NUM_REQ-1:0]         req_eof,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    output logic                       tx_sof,
    output logic                       tx_eof,
    output logic                       tx_abort,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       trunc_pulse
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_IFG   = 2'd3
    } state_t;

    state_t          state_r;
    logic [GW-1:0]   grant_r;
    logic [GW-1:0]   rr_ptr_r;
    logic [LW-1:0]   len_cnt_r;
    logic [IW-1:0]   ifg_cnt_r;
    logic            trunc_pulse_r;

    logic [NUM_REQ-1:0] req_s;
    logic               pick_vld_s;
    logic [GW-1:0]      pick_s;
    logic [GW-1:0]      rr_next_s;
    logic [7:0]         g_data_s;
    logic               g_valid_s;
    logic               g_sof_s;
    logic               g_eof_s;
    logic               at_max_s;
    logic               accept_s;
    logic               trunc_s;

    assign req_s      = req_valid & req_sof;
    assign pick_vld_s = |req_s;
    assign rr_next_s  = (pick_s == GW'(NUM_REQ - 1)) ? GW'(0) : pick_s + GW'(1);

    // Round-robin search; scanning downward leaves the nearest requester at or after rr_ptr.
    always_comb begin
        pick_s = rr_ptr_r;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pick_s = req_s[(int'(rr_ptr_r) + k) % NUM_REQ] ?
                     GW'((int'(rr_ptr_r) + k) % NUM_REQ) : pick_s;
        end
    end

    // Granted-lane mux and beat qualification.
    always_comb begin
        g_data_s  = req_data[int'(grant_r)*8 +: 8];
        g_valid_s = req_valid[grant_r];
        g_sof_s   = req_sof[grant_r];
        g_eof_s   = req_eof[grant_r];
        at_max_s  = (len_cnt_r == LW'(MAX_LEN - 1));
        accept_s  = (state_r == ST_XFER) && g_valid_s && tx_ready;
        trunc_s   = accept_s && at_max_s && !g_eof_s;
    end

    // Output drive: pass-through in XFER, swallow beats in DRAIN, idle otherwise.
    always_comb begin
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_sof    = 1'b0;
        tx_eof    = 1'b0;
        tx_abort  = 1'b0;
        req_ready = '0;
        case (state_r)
            ST_XFER: begin
                tx_data            = g_data_s;
                tx_valid           = g_valid_s;
                tx_sof             = g_sof_s;
                tx_eof             = g_eof_s | (g_valid_s & at_max_s);
                tx_abort           = trunc_s;
                req_ready[grant_r] = tx_ready;
            end
            ST_DRAIN: begin
                req_ready[grant_r] = 1'b1;
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    // Arbitration state machine, length and gap counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            grant_r       <= '0;
            rr_ptr_r      <= '0;
            len_cnt_r     <= '0;
            ifg_cnt_r     <= '0;
            trunc_pulse_r <= 1'b0;
        end else begin
            trunc_pulse_r <= trunc_s;
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        grant_r   <= pick_s;
                        rr_ptr_r  <= rr_next_s;
                        len_cnt_r <= '0;
                        state_r   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept_s) begin
                        if (len_cnt_r != {LW{1'b1}}) begin
                            len_cnt_r <= len_cnt_r + LW'(1);
                        end
                        if (g_eof_s) begin
                            state_r   <= ST_IFG;
                            ifg_cnt_r <= '0;
                        end else if (at_max_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (g_valid_s && g_eof_s) begin
                        state_r   <= ST_IFG;
                        ifg_cnt_r <= '0;
                    end
                end
                ST_IFG: begin
                    if (ifg_cnt_r == IW'(IFG_CYCLES - 1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        ifg_cnt_r <= ifg_cnt_r + IW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_id    = grant_r;
    assign busy        = (state_r != ST_IDLE);
    assign trunc_pulse = trunc_pulse_r;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: per-requester frame sources, a beat log of accepted
// MAC beats, and one task per scenario with hand-derived timing and data expectations.
module tb_eth_tx_arbiter;

    localparam int NR  = 4;
    localparam int IFG = 12;
    localparam int ML  = 1518;

    logic            clk = 1'b0;
    logic            rst;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_sof;
    logic [NR-1:0]   req_eof;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_sof;
    logic            tx_eof;
    logic            tx_abort;
    logic            tx_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic            trunc_pulse;

    eth_tx_arbiter #(.NUM_REQ(NR), .IFG_CYCLES(IFG), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_valid(req_valid), .req_sof(req_sof), .req_eof(req_eof),
        .req_ready(req_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof),
        .tx_abort(tx_abort), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy), .trunc_pulse(trunc_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       abort;
        logic [1:0] gid;
    } beat_t;

    beat_t log_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    inv_err = 0;
    int    busy_last = -1;
    int    tp_cnt = 0;
    int    tp_cyc = -1;
    int    src_len[NR];
    int    src_left[NR];
    int    src_idx[NR];
    int    src_fno[NR];
    int    acc_cnt[NR];
    logic  rst_req;
    int    rdy_mode = 0;
    int    rdy_t0 = 0;

    function automatic logic [7:0] src_byte(int r, int f, int i);
        return 8'((r*61 + i*7 + f*13) % 256);
    endfunction

    task automatic drive();
        rst      = rst_req;
        tx_ready = (rdy_mode == 0) ? 1'b1 : (((cyc - rdy_t0) % 2) == 0);
        for (int r = 0; r < NR; r++) begin
            if (src_left[r] > 0) begin
                req_valid[r]      = 1'b1;
                req_data[8*r +: 8] = src_byte(r, src_fno[r], src_idx[r]);
                req_sof[r]        = (src_idx[r] == 0);
                req_eof[r]        = (src_idx[r] == src_len[r] - 1);
            end else begin
                req_valid[r]      = 1'b0;
                req_data[8*r +: 8] = 8'h00;
                req_sof[r]        = 1'b0;
                req_eof[r]        = 1'b0;
            end
        end
    endtask

    task automatic observe();
        beat_t b;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            b.cyc = cyc; b.data = tx_data; b.sof = tx_sof; b.eof = tx_eof;
            b.abort = tx_abort; b.gid = grant_id;
            log_q.push_back(b);
        end
        for (int r = 0; r < NR; r++) begin
            if (req_valid[r] === 1'b1 && req_ready[r] === 1'b1) begin
                acc_cnt[r]++;
                src_idx[r]++;
                if (src_idx[r] == src_len[r]) begin
                    src_idx[r] = 0;
                    src_left[r]--;
                    src_fno[r]++;
                end
            end
        end
        if (tx_abort === 1'b1 && !(tx_eof === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1)) inv_err++;
        if (!$onehot0(req_ready)) inv_err++;
        if (busy === 1'b1) busy_last = cyc;
        if (trunc_pulse === 1'b1) begin
            tp_cnt++;
            tp_cyc = cyc;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        #1;
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic clear_sources();
        for (int r = 0; r < NR; r++) begin
            src_len[r] = 1; src_left[r] = 0; src_idx[r] = 0; src_fno[r] = 0; acc_cnt[r] = 0;
        end
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        cycle();
        cycle();
        clear_sources();
        log_q.delete();
        inv_err = 0; busy_last = -1; tp_cnt = 0; tp_cyc = -1; rdy_mode = 0;
    endtask

    task automatic test_reset();
        clear_sources();
        rst_req = 1'b1;
        src_len[0] = 8; src_left[0] = 1;
        repeat (3) cycle();
        checks++;
        if ({tx_valid, tx_sof, tx_eof, tx_abort, busy, trunc_pulse} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: valid/sof/eof/abort/busy/trunc=%b, expected 000000",
                     {tx_valid, tx_sof, tx_eof, tx_abort, busy, trunc_pulse});
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req_ready: got %b, expected 0000", req_ready);
        end
        checks++;
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_grant_id: got %0d, expected 0", grant_id);
        end
    endtask

    task automatic test_single_frame();
        int t;
        do_reset();
        src_len[0] = 64; src_left[0] = 1;
        rst_req = 1'b0;
        t = cyc + 1;
        cycle();
        checks++;
        if (tx_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_arb_cycle: tx_valid=%b req_ready=%b, expected 0 and 0000", tx_valid, req_ready);
        end
        repeat (90) cycle();
        checks++;
        if (log_q.size() != 64) begin
            errors++;
            $display("FAIL single_count: got %0d beats, expected 64", log_q.size());
        end
        for (int i = 0; i < log_q.size() && i < 64; i++) begin
            checks++;
            if (log_q[i].cyc != t + 1 + i || log_q[i].data !== src_byte(0, 0, i) ||
                log_q[i].sof !== (i == 0) || log_q[i].eof !== (i == 63) ||
                log_q[i].abort !== 1'b0 || log_q[i].gid !== 2'd0) begin
                errors++;
                $display("FAIL single_beat[%0d]: got cyc=%0d data=%h sof=%b eof=%b abort=%b gid=%0d, expected cyc=%0d data=%h sof=%b eof=%b abort=0 gid=0",
                         i, log_q[i].cyc, log_q[i].data, log_q[i].sof, log_q[i].eof, log_q[i].abort, log_q[i].gid,
                         t + 1 + i, src_byte(0, 0, i), (i == 0), (i == 63));
            end
        end
        checks++;
        if (busy_last != t + 64 + IFG) begin
            errors++;
            $display("FAIL single_busy_end: last busy cycle %0d, expected %0d", busy_last, t + 64 + IFG);
        end
        checks++;
        if (inv_err != 0) begin
            errors++;
            $display("FAIL single_invariants: got %0d violations, expected 0", inv_err);
        end
    endtask

    task automatic test_two_req();
        int t;
        do_reset();
        src_len[0] = 20; src_left[0] = 1;
        src_len[1] = 20; src_left[1] = 1;
        rst_req = 1'b0;
        t = cyc + 1;
        repeat (80) cycle();
        checks++;
        if (log_q.size() != 40) begin
            errors++;
            $display("FAIL two_count: got %0d beats, expected 40", log_q.size());
        end
        for (int i = 0; i < log_q.size() && i < 40; i++) begin
            int r, j, ec;
            r = i / 20; j = i % 20;
            ec = (r == 0) ? t + 1 + j : t + 34 + j;
            checks++;
            if (log_q[i].cyc != ec || log_q[i].data !== src_byte(r, 0, j) ||
                log_q[i].sof !== (j == 0) || log_q[i].eof !== (j == 19) || log_q[i].gid !== 2'(r)) begin
                errors++;
                $display("FAIL two_beat[%0d]: got cyc=%0d data=%h sof=%b eof=%b gid=%0d, expected cyc=%0d data=%h gid=%0d",
                         i, log_q[i].cyc, log_q[i].data, log_q[i].sof, log_q[i].eof, log_q[i].gid,
                         ec, src_byte(r, 0, j), r);
            end
        end
        if (log_q.size() >= 21) begin
            checks++;
            if (log_q[20].cyc - log_q[19].cyc != 14) begin
                errors++;
                $display("FAIL two_gap: got %0d cycles eof->sof, expected 14", log_q[20].cyc - log_q[19].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            src_len[r] = 60; src_left[r] = 2;
        end
        rst_req = 1'b0;
        t = cyc + 1;
        repeat (460) cycle();
        checks++;
        if (log_q.size() != 360) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats, expected 360", log_q.size());
        end
        for (int i = 0; i < log_q.size() && i < 360; i++) begin
            int k, j, r, f, ec;
            k = i / 60; j = i % 60; r = k % 3; f = k / 3;
            ec = t + 1 + k*73 + j;
            checks++;
            if (log_q[i].cyc != ec || log_q[i].data !== src_byte(r, f, j) ||
                log_q[i].sof !== (j == 0) || log_q[i].eof !== (j == 59) || log_q[i].gid !== 2'(r)) begin
                errors++;
                $display("FAIL b2b_beat[%0d]: got cyc=%0d data=%h sof=%b eof=%b gid=%0d, expected cyc=%0d data=%h gid=%0d",
                         i, log_q[i].cyc, log_q[i].data, log_q[i].sof, log_q[i].eof, log_q[i].gid,
                         ec, src_byte(r, f, j), r);
            end
        end
    endtask

    task automatic test_backpressure();
        int t;
        do_reset();
        src_len[1] = 100; src_left[1] = 1;
        rst_req = 1'b0;
        t = cyc + 1;
        rdy_mode = 1; rdy_t0 = t + 1;
        cycle();
        for (int n = 0; n < 199; n++) begin
            cycle();
            checks++;
            if (req_ready !== {2'b00, tx_ready, 1'b0}) begin
                errors++;
                $display("FAIL bp_ready_mirror[%0d]: got req_ready=%b, expected %b", n, req_ready, {2'b00, tx_ready, 1'b0});
            end
        end
        repeat (30) cycle();
        rdy_mode = 0;
        checks++;
        if (log_q.size() != 100) begin
            errors++;
            $display("FAIL bp_count: got %0d beats, expected 100", log_q.size());
        end
        for (int i = 0; i < log_q.size() && i < 100; i++) begin
            checks++;
            if (log_q[i].cyc != t + 1 + 2*i || log_q[i].data !== src_byte(1, 0, i) ||
                log_q[i].sof !== (i == 0) || log_q[i].eof !== (i == 99) || log_q[i].gid !== 2'd1) begin
                errors++;
                $display("FAIL bp_beat[%0d]: got cyc=%0d data=%h sof=%b eof=%b gid=%0d, expected cyc=%0d data=%h gid=1",
                         i, log_q[i].cyc, log_q[i].data, log_q[i].sof, log_q[i].eof, log_q[i].gid,
                         t + 1 + 2*i, src_byte(1, 0, i));
            end
        end
        checks++;
        if (busy_last != t + 199 + IFG) begin
            errors++;
            $display("FAIL bp_busy_end: last busy cycle %0d, expected %0d", busy_last, t + 199 + IFG);
        end
    endtask

    task automatic test_truncate();
        int t;
        do_reset();
        src_len[2] = 1600; src_left[2] = 1;
        rst_req = 1'b0;
        t = cyc + 1;
        repeat (1640) cycle();
        checks++;
        if (log_q.size() != ML) begin
            errors++;
            $display("FAIL trunc_count: got %0d beats on MAC, expected %0d", log_q.size(), ML);
        end
        for (int i = 0; i < log_q.size() && i < ML; i++) begin
            checks++;
            if (log_q[i].cyc != t + 1 + i || log_q[i].data !== src_byte(2, 0, i) ||
                log_q[i].sof !== (i == 0) || log_q[i].eof !== (i == ML - 1) ||
                log_q[i].abort !== (i == ML - 1) || log_q[i].gid !== 2'd2) begin
                errors++;
                $display("FAIL trunc_beat[%0d]: got cyc=%0d data=%h sof=%b eof=%b abort=%b gid=%0d, expected cyc=%0d data=%h eof=abort=%b",
                         i, log_q[i].cyc, log_q[i].data, log_q[i].sof, log_q[i].eof, log_q[i].abort, log_q[i].gid,
                         t + 1 + i, src_byte(2, 0, i), (i == ML - 1));
            end
        end
        checks++;
        if (tp_cnt != 1 || tp_cyc != t + ML + 1) begin
            errors++;
            $display("FAIL trunc_pulse: got %0d pulses last at %0d, expected 1 at %0d", tp_cnt, tp_cyc, t + ML + 1);
        end
        checks++;
        if (acc_cnt[2] != 1600) begin
            errors++;
            $display("FAIL trunc_drained: got %0d beats accepted from req2, expected 1600", acc_cnt[2]);
        end
        checks++;
        if (busy_last != t + 1600 + IFG) begin
            errors++;
            $display("FAIL trunc_busy_end: last busy cycle %0d, expected %0d", busy_last, t + 1600 + IFG);
        end
        checks++;
        if (inv_err != 0) begin
            errors++;
            $display("FAIL trunc_invariants: got %0d violations, expected 0", inv_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int t;
        do_reset();
        src_len[2] = 64; src_left[2] = 1;
        rst_req = 1'b0;
        t = cyc + 1;
        repeat (30) cycle();
        rst_req = 1'b1;
        cycle();
        checks++;
        if (tx_valid !== 1'b1 || grant_id !== 2'd2 || tx_data !== src_byte(2, 0, 29)) begin
            errors++;
            $display("FAIL midrst_byte30: got valid=%b gid=%0d data=%h, expected 1 2 %h",
                     tx_valid, grant_id, tx_data, src_byte(2, 0, 29));
        end
        rst_req = 1'b0;
        src_left[2] = 0; src_idx[2] = 0;
        src_len[3] = 10; src_left[3] = 1;
        cycle();
        checks++;
        if ({tx_valid, tx_sof, tx_eof, tx_abort, busy, trunc_pulse} !== 6'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_outputs: flags=%b data=%h, expected 000000 00",
                     {tx_valid, tx_sof, tx_eof, tx_abort, busy, trunc_pulse}, tx_data);
        end
        checks++;
        if (req_ready !== 4'b0000 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst_grant: req_ready=%b gid=%0d, expected 0000 0", req_ready, grant_id);
        end
        log_q.delete();
        repeat (30) cycle();
        checks++;
        if (log_q.size() != 10) begin
            errors++;
            $display("FAIL midrst_count: got %0d beats, expected 10", log_q.size());
        end
        for (int i = 0; i < log_q.size() && i < 10; i++) begin
            checks++;
            if (log_q[i].cyc != t + 32 + i || log_q[i].data !== src_byte(3, 0, i) ||
                log_q[i].sof !== (i == 0) || log_q[i].eof !== (i == 9) || log_q[i].gid !== 2'd3) begin
                errors++;
                $display("FAIL midrst_beat[%0d]: got cyc=%0d data=%h sof=%b eof=%b gid=%0d, expected cyc=%0d data=%h gid=3",
                         i, log_q[i].cyc, log_q[i].data, log_q[i].sof, log_q[i].eof, log_q[i].gid,
                         t + 32 + i, src_byte(3, 0, i));
            end
        end
        checks++;
        if (busy_last != t + 41 + IFG) begin
            errors++;
            $display("FAIL midrst_busy_end: last busy cycle %0d, expected %0d", busy_last, t + 41 + IFG);
        end
    endtask

    initial begin
        rst = 1'b1; rst_req = 1'b1; tx_ready = 1'b0;
        req_data = '0; req_valid = '0; req_sof = '0; req_eof = '0;
        test_reset();
        test_single_frame();
        test_two_req();
        test_back_to_back();
        test_backpressure();
        test_truncate();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
